// File: rtl/dac_frame_scheduler_if.sv
// Sample write channel between the sample generator and the frame scheduler.
interface dac_frame_scheduler_if;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_chan;

  modport master (output wr_data, output wr_valid, input wr_ready, input wr_chan);
  modport slave  (input wr_data, input wr_valid, output wr_ready, output wr_chan);
endinterface

// File: rtl/dac_frame_scheduler.sv
// Assembles 4-channel DAC frames, buffers them in a small frame FIFO and
// sequences the DAC interface enable through prefill, run and a zero-output stop.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | DAC disabled, output zero, FIFO and assembly held flushed
// PREFILL | accepting samples until prefill_frames frames are buffered
// RUN     | DAC enabled, one frame popped per dac_request, underruns counted
// STOP    | DAC still enabled, zero frame shifted out over two requests
module dac_frame_scheduler #(
  parameter int dac_channels    = 4,
  parameter int fifo_depth_log2 = 2,
  parameter int prefill_frames  = 2
) (
  input  logic                           capture_clk,
  input  logic                           reset_n,
  input  logic                           run,
  input  logic                           zero_on_underrun,
  input  logic                           dac_request,
  dac_frame_scheduler_if.slave           wr,
  output logic [32*dac_channels-1:0]     dac_buffer,
  output logic                           dac_enable,
  output logic [fifo_depth_log2:0]       fifo_level,
  output logic [15:0]                    underrun_count,
  output logic [1:0]                     state
);

  localparam int frame_w = 32 * dac_channels;
  localparam int depth   = 1 << fifo_depth_log2;
  localparam logic [fifo_depth_log2:0] depth_lvl   = (fifo_depth_log2 + 1)'(depth);
  localparam logic [fifo_depth_log2:0] prefill_lvl = (fifo_depth_log2 + 1)'(prefill_frames);

  typedef enum logic [1:0] {
    st_idle    = 2'd0,
    st_prefill = 2'd1,
    st_run     = 2'd2,
    st_stop    = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [frame_w-1:0]           fifo_mem [depth];
  logic [fifo_depth_log2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [fifo_depth_log2:0]     level_q;
  logic [frame_w-33:0]          asm_q;
  logic [1:0]                   chan_q;
  logic                         stop_cnt_q;
  logic                         accept, commit, pop, underrun, zero_buf, flush;

  assign wr.wr_ready = ((state_q == st_prefill) || (state_q == st_run)) && (level_q < depth_lvl);
  assign wr.wr_chan  = chan_q;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign commit      = accept && (chan_q == 2'd3);
  assign fifo_level  = level_q;
  assign state       = state_q;
  // Decoded from the state register so reset drops the enable asynchronously.
  assign dac_enable  = (state_q == st_run) || (state_q == st_stop);

  // State register.
  always_ff @(posedge capture_clk or negedge reset_n) begin
    if (!reset_n) state_q <= st_idle;
    else          state_q <= state_d;
  end

  // Next-state and per-cycle FIFO/buffer strobes.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    underrun = 1'b0;
    zero_buf = 1'b0;
    case (state_q)
      st_idle: begin
        zero_buf = 1'b1;
        if (run) state_d = st_prefill;
      end
      st_prefill: begin
        if (!run) begin
          state_d = st_idle;
        end else if (level_q >= prefill_lvl) begin
          state_d = st_run;
          pop     = 1'b1;
        end
      end
      st_run: begin
        // Exit wins over a coincident request: the stop sequence owns the output.
        if (!run) begin
          state_d  = st_stop;
          zero_buf = 1'b1;
        end else if (dac_request) begin
          // A commit landing this cycle is not visible yet: no fall-through.
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            underrun = 1'b1;
            zero_buf = zero_on_underrun;
          end
        end
      end
      st_stop: begin
        if (dac_request && stop_cnt_q) state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  assign flush = (state_q == st_idle) || (state_d == st_idle);

  // Frame storage; no reset so it can map onto plain registers or RAM.
  always_ff @(posedge capture_clk) begin
    if (commit) fifo_mem[wr_ptr_q] <= {asm_q, wr.wr_data};
  end

  // FIFO pointers and committed-frame level.
  always_ff @(posedge capture_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (commit) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({commit, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Channel assembly: channels 0..2 are held until channel 3 completes the frame.
  always_ff @(posedge capture_clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_q <= '0;
      asm_q  <= '0;
    end else if (flush) begin
      chan_q <= '0;
    end else if (accept) begin
      chan_q <= chan_q + 1'b1;
      case (chan_q)
        2'd0:    asm_q[95:64] <= wr.wr_data;
        2'd1:    asm_q[63:32] <= wr.wr_data;
        2'd2:    asm_q[31:0]  <= wr.wr_data;
        default: asm_q        <= asm_q;
      endcase
    end
  end

  // Output frame register and stop-sequence request counter.
  always_ff @(posedge capture_clk or negedge reset_n) begin
    if (!reset_n) begin
      dac_buffer <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      if (zero_buf)  dac_buffer <= '0;
      else if (pop)  dac_buffer <= fifo_mem[rd_ptr_q];
      if (state_q != st_stop) stop_cnt_q <= 1'b0;
      else if (dac_request)   stop_cnt_q <= 1'b1;
    end
  end

  // Saturating underrun counter, cleared only by reset.
  always_ff @(posedge capture_clk or negedge reset_n) begin
    if (!reset_n)                              underrun_count <= '0;
    else if (underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 1'b1;
  end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler with hand-computed expectations.
module tb_dac_frame_scheduler;
  logic         capture_clk = 1'b0;
  logic         reset_n;
  logic         run;
  logic         zero_on_underrun;
  logic         dac_request;
  logic [127:0] dac_buffer;
  logic         dac_enable;
  logic [2:0]   fifo_level;
  logic [15:0]  underrun_count;
  logic [1:0]   state;
  int           n_checks = 0;
  int           n_errors = 0;

  dac_frame_scheduler_if bus ();

  dac_frame_scheduler dut (
    .capture_clk      (capture_clk),
    .reset_n          (reset_n),
    .run              (run),
    .zero_on_underrun (zero_on_underrun),
    .dac_request      (dac_request),
    .wr               (bus.slave),
    .dac_buffer       (dac_buffer),
    .dac_enable       (dac_enable),
    .fifo_level       (fifo_level),
    .underrun_count   (underrun_count),
    .state            (state)
  );

  always #5 capture_clk = ~capture_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge capture_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
  endtask

  function automatic logic [31:0] w(input int f, input int c);
    return {8'(f), 8'(c), 16'hBEEF};
  endfunction

  function automatic logic [127:0] frame(input int f);
    return {w(f, 0), w(f, 1), w(f, 2), w(f, 3)};
  endfunction

  task automatic send_frame(input int f);
    for (int c = 0; c < 4; c++) send(w(f, c));
  endtask

  task automatic pulse_req();
    dac_request = 1'b1;
    step();
    dac_request = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    run = 1'b0;
    zero_on_underrun = 1'b0;
    dac_request = 1'b0;
    bus.wr_data = '0;
    bus.wr_valid = 1'b0;
    step();
    step();
    chk("rst_state", 128'(state), 128'd0);
    chk("rst_enable", 128'(dac_enable), 128'd0);
    chk("rst_buffer", dac_buffer, 128'd0);
    chk("rst_ready", 128'(bus.wr_ready), 128'd0);
    chk("rst_underrun", 128'(underrun_count), 128'd0);
    chk("rst_level", 128'(fifo_level), 128'd0);
    chk("rst_chan", 128'(bus.wr_chan), 128'd0);
    reset_n = 1'b1;
    step();

    // Prefill two frames and enter RUN.
    run = 1'b1;
    step();
    chk("prefill_state", 128'(state), 128'd1);
    chk("prefill_ready", 128'(bus.wr_ready), 128'd1);
    for (int i = 1; i <= 8; i++) send(32'(i * 32'h11) << 24);
    chk("prefill_level2", 128'(fifo_level), 128'd2);
    chk("prefill_enable_low", 128'(dac_enable), 128'd0);
    step();
    chk("run_state", 128'(state), 128'd2);
    chk("run_enable", 128'(dac_enable), 128'd1);
    chk("run_first_frame", dac_buffer, {32'h11000000, 32'h22000000, 32'h33000000, 32'h44000000});
    chk("run_level_after_pop", 128'(fifo_level), 128'd1);
    pulse_req();
    chk("run_second_frame", dac_buffer, {32'h55000000, 32'h66000000, 32'h77000000, 32'h88000000});
    chk("run_level_empty", 128'(fifo_level), 128'd0);

    // Underrun with repeat, then with zero output.
    for (int i = 0; i < 3; i++) pulse_req();
    chk("underrun_hold_buf", dac_buffer, {32'h55000000, 32'h66000000, 32'h77000000, 32'h88000000});
    chk("underrun_count3", 128'(underrun_count), 128'd3);
    zero_on_underrun = 1'b1;
    pulse_req();
    chk("underrun_zero_buf", dac_buffer, 128'd0);
    pulse_req();
    pulse_req();
    chk("underrun_count6", 128'(underrun_count), 128'd6);

    // Fill the FIFO, block on full, release with one request.
    for (int f = 1; f <= 4; f++) send_frame(f);
    chk("full_level", 128'(fifo_level), 128'd4);
    chk("full_ready", 128'(bus.wr_ready), 128'd0);
    chk("full_chan", 128'(bus.wr_chan), 128'd0);
    bus.wr_data  = w(5, 0);
    bus.wr_valid = 1'b1;
    step();
    chk("full_blocked_chan", 128'(bus.wr_chan), 128'd0);
    chk("full_blocked_level", 128'(fifo_level), 128'd4);
    dac_request = 1'b1;
    step();
    dac_request = 1'b0;
    chk("full_pop_frame1", dac_buffer, frame(1));
    chk("full_pop_level", 128'(fifo_level), 128'd3);
    chk("full_ready_again", 128'(bus.wr_ready), 128'd1);
    chk("full_still_chan0", 128'(bus.wr_chan), 128'd0);
    step();
    bus.wr_valid = 1'b0;
    chk("accept_after_full", 128'(bus.wr_chan), 128'd1);
    send(w(5, 1));
    send(w(5, 2));
    chk("partial_chan3", 128'(bus.wr_chan), 128'd3);
    dac_request = 1'b1;
    step();
    dac_request = 1'b0;
    chk("pop_frame2", dac_buffer, frame(2));
    chk("pop_level2", 128'(fifo_level), 128'd2);

    // Commit and pop on the same edge.
    bus.wr_data  = w(5, 3);
    bus.wr_valid = 1'b1;
    dac_request  = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    dac_request  = 1'b0;
    chk("simul_level", 128'(fifo_level), 128'd2);
    chk("simul_frame3", dac_buffer, frame(3));
    chk("simul_no_underrun", 128'(underrun_count), 128'd6);
    chk("simul_chan_wrap", 128'(bus.wr_chan), 128'd0);

    // Clean stop.
    run = 1'b0;
    step();
    chk("stop_state", 128'(state), 128'd3);
    chk("stop_buf_zero", dac_buffer, 128'd0);
    chk("stop_enable", 128'(dac_enable), 128'd1);
    chk("stop_ready", 128'(bus.wr_ready), 128'd0);
    dac_request = 1'b1;
    step();
    dac_request = 1'b0;
    chk("stop_after_req1_state", 128'(state), 128'd3);
    chk("stop_after_req1_enable", 128'(dac_enable), 128'd1);
    chk("stop_after_req1_buf", dac_buffer, 128'd0);
    dac_request = 1'b1;
    step();
    dac_request = 1'b0;
    chk("stop_done_state", 128'(state), 128'd0);
    chk("stop_done_enable", 128'(dac_enable), 128'd0);
    chk("stop_done_level", 128'(fifo_level), 128'd0);
    chk("stop_underrun_kept", 128'(underrun_count), 128'd6);

    // Reset in RUN with a partial frame, then restart.
    run = 1'b1;
    step();
    send_frame(6);
    send_frame(7);
    step();
    chk("rerun_state", 128'(state), 128'd2);
    chk("rerun_frame6", dac_buffer, frame(6));
    send(w(8, 0));
    send(w(8, 1));
    chk("partial_chan2", 128'(bus.wr_chan), 128'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_enable", 128'(dac_enable), 128'd0);
    chk("async_state", 128'(state), 128'd0);
    chk("async_chan", 128'(bus.wr_chan), 128'd0);
    chk("async_buf", dac_buffer, 128'd0);
    chk("async_level", 128'(fifo_level), 128'd0);
    chk("async_underrun", 128'(underrun_count), 128'd0);
    chk("async_ready", 128'(bus.wr_ready), 128'd0);
    @(negedge capture_clk);
    reset_n = 1'b1;
    step();
    chk("restart_state", 128'(state), 128'd1);
    chk("restart_chan0", 128'(bus.wr_chan), 128'd0);
    send_frame(9);
    send_frame(10);
    step();
    chk("restart_frame9", dac_buffer, frame(9));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
- Sits between the host/sample-generation logic and multi_dac_interface.
- Assembles per-channel 32-bit output samples into 4-channel frames and buffers them in a small frame FIFO.
- Presents one frame on dac_buffer per dac_request pulse.
- Sequences the DAC interface enable through prefill, run and a clean zero-output stop, and counts underruns.

Parameters:
- dac_channels, 4: channels per frame. Fixed by the DAC board; documentation only.
- fifo_depth_log2, 2: log2 of FIFO depth in frames (default 4 frames).
- prefill_frames, 2: frames required in the FIFO before the DAC is enabled. Range 1..2^fifo_depth_log2.

Ports:
- capture_clk  in  1  DAC/data-acquisition clock (SYSCLK/4).
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  software start/stop level.
- zero_on_underrun  in  1  on underrun: 1 = output zero frame, 0 = repeat last frame.
- wr_data  in  32  channel sample; the low 8 bits are ignored downstream.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  sample accepted when wr_valid & wr_ready.
- wr_chan  out  2  channel index the next accepted word is assigned to.
- dac_request  in  1  one-cycle pulse from the DAC interface at each new sample period.
- dac_buffer  out  32*dac_channels  current frame. Channel 0 in [127:96], channel 3 in [31:0].
- dac_enable  out  1  drives multi_dac_interface enable.
- fifo_level  out  fifo_depth_log2+1  committed frames held.
- underrun_count  out  16  saturating underrun counter.
- state  out  2  IDLE=0, PREFILL=1, RUN=2, STOP=3.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; FIFO empty; wr_chan=0.
  - dac_buffer=0, dac_enable=0, wr_ready=0, underrun_count=0.
- Write side:
  - wr_ready = (state==PREFILL or RUN) & (fifo_level < 2^fifo_depth_log2).
  - Accepted words fill the assembly register in channel order 0,1,2,3; wr_chan increments and wraps 3->0.
  - Accepting channel 3 commits the frame into the FIFO in the same cycle; fifo_level updates the next cycle.
  - While the FIFO is full, wr_ready is low for all channels, including a partially assembled frame.
- State IDLE:
  - dac_enable=0, dac_buffer=0. FIFO is flushed and wr_chan=0 every cycle.
  - run=1 -> PREFILL.
- State PREFILL:
  - dac_enable=0; writes accepted.
  - run=0 -> IDLE (flush).
  - fifo_level >= prefill_frames -> RUN. On this transition, pop the head frame into dac_buffer and set dac_enable=1, both registered on the same edge. The interface latches the left words at its first LRCK edge.
- State RUN, on a dac_request cycle:
  - FIFO non-empty: dac_buffer <= head; pop.
  - FIFO empty (underrun): dac_buffer <= 0 if zero_on_underrun, else hold. underrun_count increments, saturating at 16'hFFFF.
  - A commit in the same cycle as a pop leaves fifo_level unchanged. A commit into an empty FIFO on a request cycle is still an underrun: no fall-through.
- RUN exit: run=0 -> STOP. dac_buffer <= 0 on the next edge.
- State STOP:
  - dac_enable stays 1; writes refused.
  - Count 2 dac_request pulses so that the zero frame is shifted out on both L and R words. dac_buffer stays 0 and underruns are not counted.
  - After the 2nd pulse -> IDLE: dac_enable=0, FIFO flushed.
  - run re-asserted in STOP is ignored until IDLE is reached.
- dac_request outside RUN/STOP is ignored.
- underrun_count clears only on reset.
- Reset mid-operation clears everything immediately, including a partial frame. dac_enable drops asynchronously, which puts the DACs into reset.

Test Plan:
- Reset, run=1, write 8 words 0x11000000..0x88000000 -> at fifo_level==2: state RUN, dac_enable=1, dac_buffer={0x11..,0x22..,0x33..,0x44..}. First dac_request -> dac_buffer={0x55..,0x66..,0x77..,0x88..}.
- RUN with the FIFO empty, 3 dac_requests, zero_on_underrun=0 -> dac_buffer holds its last value, underrun_count=3. Repeat with zero_on_underrun=1 -> dac_buffer=0.
- Write 4 frames without requests -> fifo_level=4, wr_ready=0 with wr_chan=0. A 5th frame's channel 0 is blocked. One dac_request -> wr_ready=1 next cycle.
- Commit channel 3 in the same cycle as a dac_request with fifo_level=2 -> fifo_level stays 2, the popped frame is correct, no underrun.
- run=0 in RUN -> dac_buffer=0 next cycle, dac_enable=1 through 2 requests, then 0. State IDLE, fifo_level=0.
- Deassert reset_n with 2 channels of a frame written -> all outputs at reset values immediately. After release and run=1, the first accepted word is assigned to wr_chan=0.
